// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU control codes, RV32I opcodes and
// operand-select encodings used between decode and execute.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSub  = 4'b0001,
        AluSll  = 4'b0010,
        AluSlt  = 4'b0011,
        AluSltu = 4'b0100,
        AluXor  = 4'b0101,
        AluSrl  = 4'b0110,
        AluSra  = 4'b0111,
        AluOr   = 4'b1000,
        AluAnd  = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    typedef enum logic [1:0] {
        ASelZero = 2'b00,
        ASelRs1  = 2'b01,
        ASelPc   = 2'b10
    } a_sel_e;

    typedef enum logic [1:0] {
        BSelZero = 2'b00,
        BSelRs2  = 2'b01,
        BSelImm  = 2'b10,
        BSelFour = 2'b11
    } b_sel_e;

    // Integer funct3 map shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct fields into ALU operation, operand
// sources, destination write enable and an illegal-instruction flag.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output alu_op_e    o_alu_control,
    output a_sel_e     o_a_sel,
    output b_sel_e     o_b_sel,
    output logic       o_rd_wr_en,
    output logic       o_illegal
);

    always_comb begin
        o_alu_control = AluAdd;
        o_a_sel       = ASelZero;
        o_b_sel       = BSelZero;
        o_rd_wr_en    = 1'b0;
        o_illegal     = 1'b0;

        case (i_opcode)
            OpcOp: begin
                o_alu_control = alu_from_funct3(i_funct3, i_funct7_5);
                o_a_sel       = ASelRs1;
                o_b_sel       = BSelRs2;
                o_rd_wr_en    = 1'b1;
            end
            OpcOpImm: begin
                // No SUBI: funct7_5 only distinguishes SRAI from SRLI.
                o_alu_control = alu_from_funct3(i_funct3, i_funct7_5 && (i_funct3 == 3'b101));
                o_a_sel       = ASelRs1;
                o_b_sel       = BSelImm;
                o_rd_wr_en    = 1'b1;
            end
            OpcLoad: begin
                o_a_sel    = ASelRs1;
                o_b_sel    = BSelImm;
                o_rd_wr_en = 1'b1;
            end
            OpcStore: begin
                o_a_sel = ASelRs1;
                o_b_sel = BSelImm;
            end
            OpcBranch: begin
                case (i_funct3)
                    3'b000, 3'b001: begin
                        o_alu_control = AluSub;
                        o_a_sel       = ASelRs1;
                        o_b_sel       = BSelRs2;
                    end
                    3'b100, 3'b101: begin
                        o_alu_control = AluSlt;
                        o_a_sel       = ASelRs1;
                        o_b_sel       = BSelRs2;
                    end
                    3'b110, 3'b111: begin
                        o_alu_control = AluSltu;
                        o_a_sel       = ASelRs1;
                        o_b_sel       = BSelRs2;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OpcLui: begin
                o_b_sel    = BSelImm;
                o_rd_wr_en = 1'b1;
            end
            OpcAuipc: begin
                o_a_sel    = ASelPc;
                o_b_sel    = BSelImm;
                o_rd_wr_en = 1'b1;
            end
            OpcJal, OpcJalr: begin
                // Execute computes the link value pc + 4.
                o_a_sel    = ASelPc;
                o_b_sel    = BSelFour;
                o_rd_wr_en = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: resolves forwarded operands and ALU
// control at capture and holds them stable for the ALU under backpressure.
module id_ex_stage #(
    parameter int unsigned XLEN = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            exmem_wr_en,
    input  logic            memwb_wr_en,
    input  logic [4:0]      exmem_rd,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] exmem_data,
    input  logic [XLEN-1:0] memwb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [3:0]      alu_control,
    output logic [4:0]      rd_out,
    output logic            rd_wr_en,
    output logic            illegal
);
    import cpu_pkg::*;

    alu_op_e         w_alu_control;
    a_sel_e          w_a_sel;
    b_sel_e          w_b_sel;
    logic            w_rd_wr_en;
    logic            w_illegal;
    logic            w_accept;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;

    logic            r_valid;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [3:0]      r_alu_control;
    logic [4:0]      r_rd;
    logic            r_rd_wr_en;
    logic            r_illegal;

    alu_ctrl_decode u_decode (
        .i_opcode      (opcode),
        .i_funct3      (funct3),
        .i_funct7_5    (funct7_5),
        .o_alu_control (w_alu_control),
        .o_a_sel       (w_a_sel),
        .o_b_sel       (w_b_sel),
        .o_rd_wr_en    (w_rd_wr_en),
        .o_illegal     (w_illegal)
    );

    // The younger EX/MEM result takes priority over MEM/WB; x0 never forwards.
    function automatic logic [XLEN-1:0] forward(input logic [4:0]      addr,
                                                input logic [XLEN-1:0] rf_data);
        logic [XLEN-1:0] val;
        if (exmem_wr_en && (exmem_rd != 5'd0) && (exmem_rd == addr)) begin
            val = exmem_data;
        end else if (memwb_wr_en && (memwb_rd != 5'd0) && (memwb_rd == addr)) begin
            val = memwb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    always_comb begin
        w_fwd_rs1 = forward(rs1_addr, rs1_data);
        w_fwd_rs2 = forward(rs2_addr, rs2_data);

        case (w_a_sel)
            ASelRs1: w_op_a = w_fwd_rs1;
            ASelPc:  w_op_a = pc;
            default: w_op_a = '0;
        endcase

        case (w_b_sel)
            BSelRs2:  w_op_b = w_fwd_rs2;
            BSelImm:  w_op_b = imm;
            BSelFour: w_op_b = XLEN'(4);
            default:  w_op_b = '0;
        endcase
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_alu_control <= 4'b0000;
            r_rd          <= 5'd0;
            r_rd_wr_en    <= 1'b0;
            r_illegal     <= 1'b0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_rd_wr_en <= 1'b0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            r_op_a        <= w_op_a;
            r_op_b        <= w_op_b;
            r_alu_control <= w_alu_control;
            r_rd          <= rd_addr;
            r_rd_wr_en    <= w_rd_wr_en && (rd_addr != 5'd0);
            r_illegal     <= w_illegal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign operand_a   = r_op_a;
    assign operand_b   = r_op_b;
    assign alu_control = r_alu_control;
    assign rd_out      = r_rd;
    assign rd_wr_en    = r_rd_wr_en;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: decode map, forwarding,
// backpressure, flush, illegal opcodes and asynchronous reset.
module tb_id_ex_stage;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            exmem_wr_en;
    logic            memwb_wr_en;
    logic [4:0]      exmem_rd;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] exmem_data;
    logic [XLEN-1:0] memwb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [3:0]      alu_control;
    logic [4:0]      rd_out;
    logic            rd_wr_en;
    logic            illegal;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (rd_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .pc          (pc),
        .exmem_wr_en (exmem_wr_en),
        .memwb_wr_en (memwb_wr_en),
        .exmem_rd    (exmem_rd),
        .memwb_rd    (memwb_rd),
        .exmem_data  (exmem_data),
        .memwb_data  (memwb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .alu_control (alu_control),
        .rd_out      (rd_out),
        .rd_wr_en    (rd_wr_en),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] iv, input logic [31:0] pv);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        rs1_addr = a1;
        rs2_addr = a2;
        rd_addr  = ad;
        rs1_data = d1;
        rs2_data = d2;
        imm      = iv;
        pc       = pv;
    endtask

    task automatic no_fwd();
        exmem_wr_en = 1'b0;
        memwb_wr_en = 1'b0;
        exmem_rd    = 5'd0;
        memwb_rd    = 5'd0;
        exmem_data  = '0;
        memwb_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
        no_fwd();
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3, 32'd4);
        #3;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_tests++; if (operand_a !== 32'd0) begin n_fail++; $display("FAIL reset_a got %h want 0", operand_a); end
        n_tests++; if (operand_b !== 32'd0) begin n_fail++; $display("FAIL reset_b got %h want 0", operand_b); end
        n_tests++; if (alu_control !== 4'b0000) begin n_fail++; $display("FAIL reset_alu got %b want 0000", alu_control); end
        n_tests++; if (rd_out !== 5'd0 || rd_wr_en !== 1'b0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd got rd=%0d we=%0b ill=%0b want 0/0/0", rd_out, rd_wr_en, illegal);
        end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_op_sub();
        set_instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd15, 32'd10, 32'd0, 32'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_valid got %0b want 1", out_valid); end
        n_tests++; if (operand_a !== 32'd15 || operand_b !== 32'd10) begin
            n_fail++; $display("FAIL sub_operands got a=%0d b=%0d want 15/10", operand_a, operand_b);
        end
        n_tests++; if (alu_control !== 4'b0001 || rd_wr_en !== 1'b1 || rd_out !== 5'd3) begin
            n_fail++; $display("FAIL sub_ctrl got alu=%b we=%0b rd=%0d want 0001/1/3", alu_control, rd_wr_en, rd_out);
        end
        cycle();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_instr(7'b0010011, 3'b101, 1'b1, 5'd4, 5'd0, 5'd5, 32'h8000_0000, 32'd0, 32'd31, 32'd0);
        cycle();
        n_tests++; if (out_valid !== 1'b1 || alu_control !== 4'b0111 || operand_b !== 32'd31
                       || operand_a !== 32'h8000_0000) begin
            n_fail++; $display("FAIL srai got v=%0b alu=%b a=%h b=%0d want 1/0111/80000000/31",
                               out_valid, alu_control, operand_a, operand_b);
        end
        set_instr(7'b0010011, 3'b101, 1'b0, 5'd4, 5'd0, 5'd5, 32'h8000_0000, 32'd0, 32'd31, 32'd0);
        cycle();
        n_tests++; if (out_valid !== 1'b1 || alu_control !== 4'b0110) begin
            n_fail++; $display("FAIL srli got v=%0b alu=%b want 1/0110", out_valid, alu_control);
        end
        // ADDI with funct7_5 set must not turn into SUB.
        set_instr(7'b0010011, 3'b000, 1'b1, 5'd4, 5'd0, 5'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0);
        cycle();
        n_tests++; if (alu_control !== 4'b0000 || operand_b !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL addi got alu=%b b=%h want 0000/ffffffff", alu_control, operand_b);
        end
        set_instr(7'b0110011, 3'b111, 1'b0, 5'd4, 5'd6, 5'd5, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0);
        cycle();
        in_valid = 1'b0;
        n_tests++; if (alu_control !== 4'b1001 || operand_b !== 32'h0FF0) begin
            n_fail++; $display("FAIL and got alu=%b b=%h want 1001/00000ff0", alu_control, operand_b);
        end
        cycle();
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        in_valid = 1'b1;
        exmem_wr_en = 1'b1; exmem_rd = 5'd5; exmem_data = 32'hAAAA;
        memwb_wr_en = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hBBBB;
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd6, 5'd7, 32'h1111, 32'h2222, 32'd0, 32'd0);
        cycle();
        n_tests++; if (operand_a !== 32'hAAAA || operand_b !== 32'h2222) begin
            n_fail++; $display("FAIL fwd_exmem got a=%h b=%h want aaaa/2222", operand_a, operand_b);
        end
        exmem_rd = 5'd9;
        cycle();
        n_tests++; if (operand_a !== 32'hBBBB) begin
            n_fail++; $display("FAIL fwd_memwb got a=%h want bbbb", operand_a);
        end
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd6, 5'd7, 32'h1234, 32'h2222, 32'd0, 32'd0);
        cycle();
        n_tests++; if (operand_a !== 32'h1234) begin
            n_fail++; $display("FAIL fwd_x0 got a=%h want 1234", operand_a);
        end
        // Forwarding must not override the immediate operand.
        exmem_rd = 5'd6;
        set_instr(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd6, 5'd7, 32'h10, 32'h2222, 32'h55, 32'd0);
        cycle();
        in_valid = 1'b0;
        n_tests++; if (operand_a !== 32'h10 || operand_b !== 32'h55) begin
            n_fail++; $display("FAIL fwd_imm got a=%h b=%h want 10/55", operand_a, operand_b);
        end
        no_fwd();
        cycle();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd3, 5'd4, 5'd9, 32'h33, 32'h44, 32'd0, 32'd0);
        cycle();
        set_instr(7'b0110011, 3'b000, 1'b1, 5'd3, 5'd4, 5'd8, 32'h99, 32'h11, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || operand_a !== 32'h33
                           || operand_b !== 32'h44 || alu_control !== 4'b0000
                           || rd_out !== 5'd9 || rd_wr_en !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d] got rdy=%0b v=%0b a=%h b=%h alu=%b rd=%0d want 0/1/33/44/0000/9",
                                   i, in_ready, out_valid, operand_a, operand_b, alu_control, rd_out);
            end
            cycle();
        end
        set_instr(7'b0110011, 3'b100, 1'b0, 5'd3, 5'd4, 5'd10, 32'hF0, 32'h0F, 32'd0, 32'd0);
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %0b want 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || alu_control !== 4'b0101 || operand_a !== 32'hF0
                       || rd_out !== 5'd10) begin
            n_fail++; $display("FAIL stall_next got v=%0b alu=%b a=%h rd=%0d want 1/0101/f0/10",
                               out_valid, alu_control, operand_a, rd_out);
        end
        cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0, 32'd0);
        cycle();
        set_instr(7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 32'h200);
        flush = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %0b want 1", in_ready); end
        cycle();
        flush = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || rd_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL flush got v=%0b we=%0b want 0/0", out_valid, rd_wr_en);
        end
        set_instr(7'b0010111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h2000, 32'h100);
        cycle();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || operand_a !== 32'h100 || operand_b !== 32'h2000
                       || alu_control !== 4'b0000 || rd_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL auipc got v=%0b a=%h b=%h alu=%b we=%0b want 1/100/2000/0000/1",
                               out_valid, operand_a, operand_b, alu_control, rd_wr_en);
        end
        cycle();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h33, 32'h44);
        cycle();
        n_tests++; if (out_valid !== 1'b1 || illegal !== 1'b1 || rd_wr_en !== 1'b0
                       || operand_a !== 32'd0 || operand_b !== 32'd0 || alu_control !== 4'b0000) begin
            n_fail++; $display("FAIL illegal_op got v=%0b ill=%0b we=%0b a=%h b=%h alu=%b want 1/1/0/0/0/0000",
                               out_valid, illegal, rd_wr_en, operand_a, operand_b, alu_control);
        end
        set_instr(7'b1100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 32'h33, 32'h44);
        cycle();
        n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL branch_010 got ill=%0b want 1", illegal); end
        set_instr(7'b1100011, 3'b110, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 32'h44);
        cycle();
        n_tests++; if (illegal !== 1'b0 || alu_control !== 4'b0100 || rd_wr_en !== 1'b0
                       || operand_b !== 32'h22) begin
            n_fail++; $display("FAIL bltu got ill=%0b alu=%b we=%0b b=%h want 0/0100/0/22",
                               illegal, alu_control, rd_wr_en, operand_b);
        end
        set_instr(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd1, 32'h11, 32'h22, 32'h800, 32'h40);
        cycle();
        n_tests++; if (operand_a !== 32'h40 || operand_b !== 32'd4 || rd_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL jal got a=%h b=%h we=%0b want 40/4/1", operand_a, operand_b, rd_wr_en);
        end
        set_instr(7'b1100111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 32'h800, 32'h40);
        cycle();
        n_tests++; if (rd_wr_en !== 1'b0) begin n_fail++; $display("FAIL jalr_x0 got we=%0b want 0", rd_wr_en); end
        set_instr(7'b0110111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd2, 32'h11, 32'h22, 32'h1234_5000, 32'h40);
        cycle();
        n_tests++; if (operand_a !== 32'd0 || operand_b !== 32'h1234_5000) begin
            n_fail++; $display("FAIL lui got a=%h b=%h want 0/12345000", operand_a, operand_b);
        end
        set_instr(7'b0100011, 3'b010, 1'b1, 5'd1, 5'd2, 5'd2, 32'h11, 32'h22, 32'h8, 32'h40);
        cycle();
        in_valid = 1'b0;
        n_tests++; if (rd_wr_en !== 1'b0 || alu_control !== 4'b0000 || operand_a !== 32'h11
                       || operand_b !== 32'h8) begin
            n_fail++; $display("FAIL store got we=%0b alu=%b a=%h b=%h want 0/0000/11/8",
                               rd_wr_en, alu_control, operand_a, operand_b);
        end
        cycle();
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_instr(7'b0110011, 3'b110, 1'b0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'd0, 32'd0);
        cycle();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || alu_control !== 4'b1000) begin
            n_fail++; $display("FAIL pre_reset got v=%0b alu=%b want 1/1000", out_valid, alu_control);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || operand_a !== 32'd0 || operand_b !== 32'd0
                       || alu_control !== 4'b0000 || rd_out !== 5'd0 || rd_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got v=%0b a=%h b=%h alu=%b rd=%0d we=%0b want all 0",
                               out_valid, operand_a, operand_b, alu_control, rd_out, rd_wr_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_op_sub();
        test_back_to_back();
        test_forward();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
